// File: rtl/mul_final_stage_pkg.sv
// Shared definitions for the multiplier back end: default widths, M-extension
// opcode encodings and the helper that decides which product word an op returns.
// Ports: none (package only).

`ifndef MUL_FINAL_STAGE_DEFINES
`define MUL_FINAL_STAGE_DEFINES
`define WORD_WIDTH    32
`define MUL_OP_MUL    2'b00
`define MUL_OP_MULH   2'b01
`define MUL_OP_MULHSU 2'b10
`define MUL_OP_MULHU  2'b11
`endif

package mul_final_stage_pkg;

   localparam int DEF_WORD_WIDTH = `WORD_WIDTH;
   localparam int DEF_TAG_WIDTH  = 6;

   typedef enum logic [1:0] {
      MUL_OP_MUL    = `MUL_OP_MUL,
      MUL_OP_MULH   = `MUL_OP_MULH,
      MUL_OP_MULHSU = `MUL_OP_MULHSU,
      MUL_OP_MULHU  = `MUL_OP_MULHU
   } mul_op_e;

   // Every op except MUL returns the upper word. Sign treatment of the operands
   // has already been folded into the partial products upstream, so all three
   // high variants select the same bits here.
   function automatic logic op_selects_high(input mul_op_e op);
      logic high;
      case (op)
         MUL_OP_MUL:    high = 1'b0;
         MUL_OP_MULH,
         MUL_OP_MULHSU,
         MUL_OP_MULHU:  high = 1'b1;
         default:       high = 1'b0;
      endcase
      return high;
   endfunction

endpackage

// File: rtl/mul_result_sel.sv
// Combinational result-word select from a resolved product; also used by the bypass path.
// Ports: product (resolved sum, PRODUCT_WIDTH bits), op (M-extension opcode) in;
//        result (WORD_WIDTH-bit architectural word) out.

module mul_result_sel
   import mul_final_stage_pkg::*;
#(
   parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
   parameter int PRODUCT_WIDTH = 2 * (WORD_WIDTH + 1)
) (
   input  logic [PRODUCT_WIDTH-1:0] product,
   input  logic [1:0]               op,
   output logic [WORD_WIDTH-1:0]    result
);

   // Bits above the double word only exist because the redundant form needs
   // guard bits; they never reach the architectural result.
   logic [PRODUCT_WIDTH-2*WORD_WIDTH-1:0] unused_guard_bits;
   assign unused_guard_bits = product[PRODUCT_WIDTH-1:2*WORD_WIDTH];

   always_comb begin
      result = product[WORD_WIDTH-1:0];
      if (op_selects_high(mul_op_e'(op))) begin
         result = product[2*WORD_WIDTH-1:WORD_WIDTH];
      end
   end

endmodule

// File: rtl/mul_final_stage.sv
// Multiplier back end: resolves the Wallace sum/carry pair with a carry-propagate
// add and delivers the selected word through a two-entry valid/ready pipeline.
// Ports: clk, rst_n; in_valid/in_ready with in_add_a, in_add_b, in_op, in_tag;
//        flush; out_valid/out_ready with out_result, out_tag.

module mul_final_stage
   import mul_final_stage_pkg::*;
#(
   parameter int WORD_WIDTH            = DEF_WORD_WIDTH,
   parameter int PARTIAL_PRODUCT_WIDTH = 2 * (WORD_WIDTH + 1),
   parameter int TAG_WIDTH             = DEF_TAG_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst_n,

   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [PARTIAL_PRODUCT_WIDTH-1:0] in_add_a,
   input  logic [PARTIAL_PRODUCT_WIDTH-1:0] in_add_b,
   input  logic [1:0]                       in_op,
   input  logic [TAG_WIDTH-1:0]             in_tag,

   input  logic                             flush,

   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [WORD_WIDTH-1:0]            out_result,
   output logic [TAG_WIDTH-1:0]             out_tag
);

   // S1: raw operand pair
   logic                             s1_valid;
   logic [PARTIAL_PRODUCT_WIDTH-1:0] s1_a;
   logic [PARTIAL_PRODUCT_WIDTH-1:0] s1_b;
   logic [1:0]                       s1_op;
   logic [TAG_WIDTH-1:0]             s1_tag;

   // S2: resolved product
   logic                             s2_valid;
   logic [PARTIAL_PRODUCT_WIDTH-1:0] s2_product;
   logic [1:0]                       s2_op;
   logic [TAG_WIDTH-1:0]             s2_tag;

   logic                             s1_sum_carry_out_dropped;
   logic [PARTIAL_PRODUCT_WIDTH-1:0] s1_sum;
   logic                             s2_adv;
   logic                             in_xfer;
   logic                             out_xfer;

   // Sum is taken modulo 2^PARTIAL_PRODUCT_WIDTH; the redundant pair may
   // legitimately overflow and the carry out carries no information.
   assign s1_sum = s1_a + s1_b;
   assign s1_sum_carry_out_dropped = 1'b0;

   // S2 takes S1 when it is empty or draining this cycle. A flush blocks the
   // drain so nothing is handed off in the flush cycle.
   assign s2_adv    = s1_valid & (~s2_valid | (out_ready & ~flush));
   assign in_ready  = ~flush & (~s1_valid | s2_adv);
   assign out_valid = s2_valid & ~flush;

   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;

   // Valid bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else if (flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (in_xfer) begin
            s1_valid <= 1'b1;
         end else if (s2_adv) begin
            s1_valid <= 1'b0;
         end

         if (s2_adv) begin
            s2_valid <= 1'b1;
         end else if (out_xfer) begin
            s2_valid <= 1'b0;
         end
      end
   end

   // S1 payload: loads only on an accepted input, otherwise holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_a   <= '0;
         s1_b   <= '0;
         s1_op  <= MUL_OP_MUL;
         s1_tag <= '0;
      end else if (in_xfer) begin
         s1_a   <= in_add_a;
         s1_b   <= in_add_b;
         s1_op  <= in_op;
         s1_tag <= in_tag;
      end
   end

   // S2 payload: reset to zero so the output word and tag read zero after
   // reset; holds while stalled so the presented result stays stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_product <= '0;
         s2_op      <= MUL_OP_MUL;
         s2_tag     <= '0;
      end else if (s2_adv) begin
         s2_product <= s1_sum;
         s2_op      <= s1_op;
         s2_tag     <= s1_tag;
      end
   end

   mul_result_sel #(
      .WORD_WIDTH    (WORD_WIDTH),
      .PRODUCT_WIDTH (PARTIAL_PRODUCT_WIDTH)
   ) u_result_sel (
      .product (s2_product),
      .op      (s2_op),
      .result  (out_result)
   );

   assign out_tag = s2_tag;

   logic unused_signals;
   assign unused_signals = s1_sum_carry_out_dropped;

endmodule

// File: tb/tb_mul_final_stage.sv
// Self-checking bench for mul_final_stage: directed vector table plus
// hand-written backpressure, flush and mid-stream reset sequences.
// Ports: none (top-level bench).

module tb_mul_final_stage;

   localparam int WW  = 32;
   localparam int PPW = 66;
   localparam int TW  = 6;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [PPW-1:0] in_add_a;
   logic [PPW-1:0] in_add_b;
   logic [1:0]     in_op;
   logic [TW-1:0]  in_tag;
   logic           flush;
   logic           out_valid;
   logic           out_ready;
   logic [WW-1:0]  out_result;
   logic [TW-1:0]  out_tag;

   int checks;
   int errors;

   typedef struct {
      string          name;
      logic [1:0]     op;
      logic [PPW-1:0] a;
      logic [PPW-1:0] b;
      logic [TW-1:0]  tag;
      logic [WW-1:0]  exp_result;
   } vec_t;

   vec_t vecs[8];

   mul_final_stage #(
      .WORD_WIDTH            (WW),
      .PARTIAL_PRODUCT_WIDTH (PPW),
      .TAG_WIDTH             (TW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_add_a   (in_add_a),
      .in_add_b   (in_add_b),
      .in_op      (in_op),
      .in_tag     (in_tag),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_op(input logic [1:0] op, input logic [PPW-1:0] a,
                           input logic [PPW-1:0] b, input logic [TW-1:0] tag);
      in_valid = 1'b1;
      in_op    = op;
      in_add_a = a;
      in_add_b = b;
      in_tag   = tag;
   endtask

   // One op through an idle pipe with out_ready held high: accepted at the
   // first edge, visible after the second, gone after the third.
   task automatic run_vec(input vec_t v);
      @(negedge clk);
      out_ready = 1'b1;
      drive_op(v.op, v.a, v.b, v.tag);
      #1;
      check({v.name, ".in_ready"}, 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check({v.name, ".early_valid"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      check({v.name, ".out_valid"}, 64'(out_valid), 64'd1);
      check({v.name, ".result"}, 64'(out_result), 64'(v.exp_result));
      check({v.name, ".tag"}, 64'(out_tag), 64'(v.tag));
      @(negedge clk);
      check({v.name, ".drained"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      int accepted;
      int delivered;
      logic [TW-1:0] exp_tag;

      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_add_a  = '0;
      in_add_b  = '0;
      in_op     = 2'b00;
      in_tag    = '0;
      flush     = 1'b0;
      out_ready = 1'b1;

      vecs[0] = '{"mul_low",     2'b00, 66'h0_0000_0000_0000_0007, 66'h0_0000_0000_0000_0005, 6'd3,  32'h0000_000C};
      vecs[1] = '{"mulhu_high",  2'b11, 66'h0_FFFF_FFFE_0000_0000, 66'h0_0000_0000_0000_0001, 6'd4,  32'hFFFF_FFFE};
      vecs[2] = '{"mul_samepair",2'b00, 66'h0_FFFF_FFFE_0000_0000, 66'h0_0000_0000_0000_0001, 6'd5,  32'h0000_0001};
      vecs[3] = '{"mulh_wrap",   2'b01, 66'h3_FFFF_FFFF_FFFF_FFFF, 66'h0_0000_0000_0000_0001, 6'd6,  32'h0000_0000};
      vecs[4] = '{"mulh_neg",    2'b01, 66'h3_FFFF_FFFF_FFFF_FFFE, 66'h0_0000_0000_0000_0000, 6'd7,  32'hFFFF_FFFF};
      vecs[5] = '{"mulhsu_high", 2'b10, 66'h0_1234_5678_9ABC_DEF0, 66'h0_0000_0000_0000_0010, 6'd8,  32'h1234_5678};
      vecs[6] = '{"mul_carry",   2'b00, 66'h0_0000_0000_FFFF_FFFF, 66'h0_0000_0000_0000_0001, 6'd9,  32'h0000_0000};
      vecs[7] = '{"mulhu_carry", 2'b11, 66'h0_0000_0000_FFFF_FFFF, 66'h0_0000_0000_0000_0001, 6'd63, 32'h0000_0001};

      // Reset state, observed while the clock is still in its first half-period.
      #2;
      check("rst.out_valid",  64'(out_valid),  64'd0);
      check("rst.out_result", 64'(out_result), 64'd0);
      check("rst.out_tag",    64'(out_tag),    64'd0);
      check("rst.in_ready",   64'(in_ready),   64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i]);
      end

      // Backpressure: 4 ops (tags 0..3, result = 100 + tag), out_ready low for
      // cycles 0..6 so the stall lasts 5 cycles once S2 is valid.
      accepted  = 0;
      delivered = 0;
      exp_tag   = '0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         out_ready = (c >= 7);
         if (accepted < 4) begin
            drive_op(2'b00, PPW'(100 + accepted), '0, TW'(accepted));
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (c == 2) begin
            check("bp.in_ready_full", 64'(in_ready), 64'd0);
            check("bp.accepts_before_full", 64'(accepted), 64'd2);
         end
         if (c >= 2 && c <= 6) begin
            check("bp.stall_valid",  64'(out_valid),  64'd1);
            check("bp.stall_tag",    64'(out_tag),    64'd0);
            check("bp.stall_result", 64'(out_result), 64'd100);
         end
         if (out_valid && out_ready) begin
            check("bp.order_tag", 64'(out_tag), 64'(exp_tag));
            check("bp.order_result", 64'(out_result), 64'(100 + int'(exp_tag)));
            exp_tag = exp_tag + 1'b1;
            delivered++;
         end
         if (in_valid && in_ready) accepted++;
         if (c == 10) check("bp.back_to_back", 64'(delivered), 64'd4);
      end
      check("bp.accepted",  64'(accepted),  64'd4);
      check("bp.delivered", 64'(delivered), 64'd4);
      in_valid = 1'b0;

      // Flush with two ops in flight and a third offered in the flush cycle.
      @(negedge clk);
      out_ready = 1'b1;
      drive_op(2'b00, 66'd10, 66'd0, 6'd10);
      @(negedge clk);
      drive_op(2'b00, 66'd11, 66'd0, 6'd11);
      @(negedge clk);
      drive_op(2'b00, 66'd12, 66'd0, 6'd12);
      check("fl.pre_valid", 64'(out_valid), 64'd1);
      flush = 1'b1;
      #1;
      check("fl.out_valid_flush", 64'(out_valid), 64'd0);
      check("fl.in_ready_flush",  64'(in_ready),  64'd0);
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("fl.out_valid_after", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("fl.no_stale", 64'(out_valid), 64'd0);
      run_vec('{"fl.next", 2'b00, 66'd20, 66'd22, 6'd13, 32'd42});

      // Asynchronous reset in the middle of a stalled, full pipe.
      @(negedge clk);
      out_ready = 1'b0;
      drive_op(2'b11, 66'h0_AAAA_AAAA_0000_0000, 66'd0, 6'd21);
      @(negedge clk);
      drive_op(2'b11, 66'h0_BBBB_BBBB_0000_0000, 66'd0, 6'd22);
      @(negedge clk);
      in_valid = 1'b0;
      check("rs.pre_valid", 64'(out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rs.out_valid",  64'(out_valid),  64'd0);
      check("rs.out_result", 64'(out_result), 64'd0);
      check("rs.out_tag",    64'(out_tag),    64'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      check("rs.released_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("rs.no_stale", 64'(out_valid), 64'd0);
      run_vec('{"rs.first", 2'b01, 66'h0_1111_2222_3333_4444, 66'h0_0000_0001_0000_0000, 6'd30, 32'h1111_2223});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute bound so the run ends even if the sequences above stall.
   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/mul_final_stage.md
# mul_final_stage

Back end of the multiplier datapath: accepts the redundant sum/carry pair produced by the Wallace-tree reduction, together with the RISC-V M-extension opcode and the reorder-buffer tag. It resolves the pair with a full-width carry-propagate add and selects the low or high result word. It delivers the result to writeback through a two-stage valid/ready pipeline that supports backpressure and flush.

## Interface
Parameters:
- WORD_WIDTH, `WORD_WIDTH (32), architectural result width
- PARTIAL_PRODUCT_WIDTH, 2*(WORD_WIDTH+1) (66), width of the sum/carry inputs
- TAG_WIDTH, 6, ROB tag width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  rising-edge clock
  - rst_n  in  1  asynchronous active-low reset
- Input side:
  - in_valid  in  1  sum/carry pair valid
  - in_ready  out  1  stage can accept this cycle
  - in_add_a  in  PARTIAL_PRODUCT_WIDTH  Wallace sum vector
  - in_add_b  in  PARTIAL_PRODUCT_WIDTH  Wallace carry vector
  - in_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
  - in_tag  in  TAG_WIDTH  ROB tag
- Control:
  - flush  in  1  kill all in-flight operations
- Output side:
  - out_valid  out  1  result valid
  - out_ready  in  1  writeback accepts
  - out_result  out  WORD_WIDTH  selected result word
  - out_tag  out  TAG_WIDTH  tag of out_result

## Operation
- Two register stages:
  - S1 captures a, b, op, tag.
  - S2 holds product = (a + b) mod 2^PARTIAL_PRODUCT_WIDTH, plus op and tag.
- The adder sits between S1 and S2.
- Result select is combinational from S2:
  - MUL: product[WORD_WIDTH-1:0]
  - MULH, MULHSU, MULHU: product[2*WORD_WIDTH-1:WORD_WIDTH]
  - Bits above 2*WORD_WIDTH are discarded.
  - Operand sign handling is upstream; this block never sign-adjusts.
- Handshake:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
  - s2_adv = s1_valid & (!s2_valid | (out_ready & !flush)).
  - in_ready = !flush & (!s1_valid | s2_adv).
- On each edge:
  - S2 loads from S1 when s2_adv.
  - S2 clears when an output transfer occurs with no new load.
  - S1 loads on an input transfer and clears when s2_adv occurs with no input transfer.
- out_valid = s2_valid & !flush.
- Payload registers hold while stalled. out_result and out_tag are stable while out_valid=1 and out_ready=0.
- Flush:
  - At the edge with flush=1, s1_valid and s2_valid clear.
  - No input is accepted and no output is handed off in the flush cycle.
- Simultaneous full pipe, output transfer and input transfer: all three transfers happen in one cycle, with no bubble.

## Timing
- Reset (asynchronous, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_tag=0. in_ready=1 when flush=0.
- Latency: an input transferred at edge N gives out_valid=1 after edge N+1, assuming no stall.
- Throughput: one operation per cycle.
- Capacity: two operations. With the pipe full and out_ready=0, in_ready=0.
- Reset mid-operation discards everything. The first accept after rst_n rises yields normal latency.
- No combinational path from in_valid, in_add_a or in_add_b to the outputs.
- out_ready feeds in_ready combinationally, by design.
- flush feeds out_valid and in_ready combinationally.

## Structure
- Opcode encodings go in define.v next to `WORD_WIDTH: `MUL_OP_MUL 2'b00, `MUL_OP_MULH 2'b01, `MUL_OP_MULHSU 2'b10, `MUL_OP_MULHU 2'b11.
- One combinational sub-module, mul_result_sel. It takes product and op and returns the result word, and is reused by the bypass path.
- The adder is a plain `+`, with synthesis choosing the architecture.
- The handshake and valid logic live in mul_final_stage.

## Test plan
- Low word: MUL with a=0x0_0000_0000_0000_0007, b=0x0_0000_0000_0000_0005, tag=3 -> out_result=0x0000000C, out_tag=3, two cycles after accept.
- High word: MULHU with a=0x0_FFFF_FFFE_0000_0000, b=0x0_0000_0000_0000_0001 -> out_result=0xFFFFFFFE. The same pair with op MUL -> 0x00000001.
- Wrap and negative: MULH with a=0x3_FFFF_FFFF_FFFF_FFFF, b=0x0_0000_0000_0000_0001 (sum wraps to 0) -> out_result=0x00000000. With a=0x3_FFFF_FFFF_FFFF_FFFE, b=0 -> 0xFFFFFFFF.
- Backpressure: stream 4 ops with tags 0..3 and hold out_ready=0 for 5 cycles.
  - in_ready falls after 2 accepts.
  - Outputs stay stable while stalled.
  - Releasing out_ready delivers tags 0,1,2,3 in order, one per cycle, with none lost or duplicated.
- Flush: with 2 ops in flight, pulse flush for one cycle while in_valid=1.
  - out_valid=0 in that cycle and the next.
  - in_ready=0 during the flush cycle.
  - The next op is delivered with normal 2-cycle latency.
- Reset: assert rst_n=0 asynchronously mid-stream -> out_valid drops immediately, out_result=0 and out_tag=0; no stale result appears after release.
